// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// registers the immediate-extender select and counts retired instructions.
//
// state  | meaning
// FETCH  | load IR
// DECODE | classify opcode, latch class and EXTOp
// EXEC   | ALU step; branches retire here
// MEM    | data access, held until mem_ready; stores retire here
// WB     | register write and PC update
// HALT   | ECALL/EBREAK or illegal opcode, wait for reset
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        rf_we,
    output logic [1:0]  wd_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic [5:0]  EXTOp,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_JTYPE       = 6'b000001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_LUI,
        C_AUIPC, C_JAL, C_JALR, C_SYSTEM, C_ILLEGAL
    } class_t;

    state_t     st;
    class_t     cls;
    class_t     dec_cls;
    logic [5:0] dec_ext;
    logic       unused_inst;

    assign state       = st;
    assign unused_inst = &{1'b0, inst_in[31:15], inst_in[11:7]};

    always_comb begin
        dec_cls = C_ILLEGAL;
        dec_ext = 6'b000000;
        case (inst_in[6:0])
            7'b0110011: dec_cls = C_OP;
            7'b0010011: begin
                dec_cls = C_OPIMM;
                dec_ext = (inst_in[13:12] == 2'b01) ? EXT_ITYPE_SHAMT : EXT_ITYPE;
            end
            7'b0000011: begin dec_cls = C_LOAD;   dec_ext = EXT_ITYPE; end
            7'b1100111: begin dec_cls = C_JALR;   dec_ext = EXT_ITYPE; end
            7'b0100011: begin dec_cls = C_STORE;  dec_ext = EXT_STYPE; end
            7'b1100011: begin dec_cls = C_BRANCH; dec_ext = EXT_BTYPE; end
            7'b0110111: begin dec_cls = C_LUI;    dec_ext = EXT_UTYPE; end
            7'b0010111: begin dec_cls = C_AUIPC;  dec_ext = EXT_UTYPE; end
            7'b1101111: begin dec_cls = C_JAL;    dec_ext = EXT_JTYPE; end
            7'b1110011: dec_cls = C_SYSTEM;
            default:    dec_cls = C_ILLEGAL;
        endcase
    end

    // Strobes are forced low during reset so an aborted instruction never retires.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        rf_we   = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        npc_sel = 2'b00;
        wd_sel  = 2'b00;
        if (!rst) begin
            case (st)
                S_FETCH: ir_we = 1'b1;
                S_EXEC: begin
                    if (cls == C_BRANCH) begin
                        pc_we   = 1'b1;
                        npc_sel = br_taken ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    if (cls == C_LOAD) begin
                        mem_re = 1'b1;
                    end else if (cls == C_STORE) begin
                        mem_we = 1'b1;
                        pc_we  = mem_ready;
                    end
                end
                S_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    if (cls == C_LOAD)
                        wd_sel = 2'b01;
                    else if (cls == C_JAL || cls == C_JALR)
                        wd_sel = 2'b10;
                    if (cls == C_JAL)
                        npc_sel = 2'b10;
                    else if (cls == C_JALR)
                        npc_sel = 2'b11;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= S_FETCH;
            cls     <= C_OP;
            EXTOp   <= 6'b000000;
            illegal <= 1'b0;
            instret <= 32'd0;
        end else begin
            if (pc_we)
                instret <= instret + 32'd1;
            case (st)
                S_FETCH: st <= S_DECODE;
                S_DECODE: begin
                    cls   <= dec_cls;
                    EXTOp <= dec_ext;
                    if (dec_cls == C_ILLEGAL) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end else if (dec_cls == C_SYSTEM) begin
                        st <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cls == C_BRANCH)
                        st <= S_FETCH;
                    else if (cls == C_LOAD || cls == C_STORE)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)
                        st <= (cls == C_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:    st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-instruction phase model predicts every output each
// cycle; a few literal checks pin cycle counts, EXTOp codes and counter values.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_in = 32'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_we, pc_we, rf_we, mem_re, mem_we, illegal;
    logic [1:0]  npc_sel, wd_sel;
    logic [5:0]  EXTOp;
    logic [2:0]  state;
    logic [31:0] instret;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .br_taken(br_taken),
        .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
        .rf_we(rf_we), .wd_sel(wd_sel), .mem_re(mem_re), .mem_we(mem_we),
        .EXTOp(EXTOp), .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir, pc, rf, re, we;
        logic [1:0]  npc, wd;
        logic [5:0]  ext;
        logic        chk_ext;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_cur;
    logic        exp_valid = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt_re = 0, cnt_we = 0, cnt_rf = 0;
    logic [5:0]  m_ext = 6'd0;
    logic        m_ill = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    int          ncyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [5:0] ext_of(input logic [31:0] inst);
        case (inst[6:0])
            7'b0010011: ext_of = (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) ? 6'b100000 : 6'b010000;
            7'b0000011, 7'b1100111: ext_of = 6'b010000;
            7'b0100011: ext_of = 6'b001000;
            7'b1100011: ext_of = 6'b000100;
            7'b0110111, 7'b0010111: ext_of = 6'b000010;
            7'b1101111: ext_of = 6'b000001;
            default:    ext_of = 6'b000000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state", state, exp_cur.st);
            chk("ir_we", ir_we, exp_cur.ir);
            chk("pc_we", pc_we, exp_cur.pc);
            chk("rf_we", rf_we, exp_cur.rf);
            chk("mem_re", mem_re, exp_cur.re);
            chk("mem_we", mem_we, exp_cur.we);
            chk("npc_sel", npc_sel, exp_cur.npc);
            chk("wd_sel", wd_sel, exp_cur.wd);
            if (exp_cur.chk_ext) chk("EXTOp", EXTOp, exp_cur.ext);
            chk("illegal", illegal, exp_cur.ill);
            chk("instret", instret, exp_cur.cnt);
            cnt_re += int'(mem_re);
            cnt_we += int'(mem_we);
            cnt_rf += int'(rf_we);
        end
    end

    task automatic model_reset();
        m_ext = 6'd0;
        m_ill = 1'b0;
        m_cnt = 32'd0;
    endtask

    // One instruction. waits = mem_ready-low MEM cycles, or HALT cycles for halting kinds.
    // abort_at >= 0 asserts rst mid-cycle at that phase index.
    task automatic run(input logic [31:0] inst, input logic br, input int waits,
                       input int abort_at, output int len);
        int ph[$];
        logic [6:0] op;
        logic ld, sto, bra, jal, jalr, sys, ill, halt;
        exp_t e;
        op   = inst[6:0];
        ld   = (op == 7'b0000011);
        sto  = (op == 7'b0100011);
        bra  = (op == 7'b1100011);
        jal  = (op == 7'b1101111);
        jalr = (op == 7'b1100111);
        sys  = (op == 7'b1110011);
        ill  = !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011});
        halt = sys || ill;
        ph.push_back(0);
        ph.push_back(1);
        if (halt) begin
            repeat (waits) ph.push_back(5);
        end else if (bra) begin
            ph.push_back(2);
        end else if (ld || sto) begin
            ph.push_back(2);
            repeat (waits + 1) ph.push_back(3);
            if (ld) ph.push_back(4);
        end else begin
            ph.push_back(2);
            ph.push_back(4);
        end
        len = ph.size();
        for (int i = 0; i < ph.size(); i++) begin
            int  p;
            logic last_mem;
            p        = ph[i];
            last_mem = (p == 3) && (i + 1 == ph.size() || ph[i+1] != 3);
            inst_in   = inst;
            br_taken  = br;
            mem_ready = (p == 3) ? last_mem : 1'b1;
            if (i == abort_at) begin
                exp_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("abort_state", state, 32'd0);
                chk("abort_pc_we", pc_we, 32'd0);
                chk("abort_rf_we", rf_we, 32'd0);
                chk("abort_mem_re", mem_re, 32'd0);
                chk("abort_instret", instret, 32'd0);
                chk("abort_ext", EXTOp, 32'd0);
                @(posedge clk);
                #1;
                chk("abort_hold_ir_we", ir_we, 32'd0);
                chk("abort_hold_state", state, 32'd0);
                rst = 1'b0;
                model_reset();
                len = i;
                return;
            end
            e.st      = 3'(p);
            e.ir      = (p == 0);
            e.pc      = (p == 2 && bra) || (p == 3 && sto && last_mem) || (p == 4);
            e.rf      = (p == 4);
            e.re      = (p == 3 && ld);
            e.we      = (p == 3 && sto);
            e.npc     = (p == 2 && bra) ? (br ? 2'b01 : 2'b00) :
                        (p == 4) ? (jal ? 2'b10 : (jalr ? 2'b11 : 2'b00)) : 2'b00;
            e.wd      = (p == 4) ? (ld ? 2'b01 : ((jal || jalr) ? 2'b10 : 2'b00)) : 2'b00;
            e.ext     = (p <= 1) ? m_ext : ext_of(inst);
            e.chk_ext = (p != 5);
            e.ill     = m_ill;
            e.cnt     = m_cnt;
            exp_cur   = e;
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
            if (e.pc) m_cnt = m_cnt + 32'd1;
            if (p == 1) begin
                m_ext = ext_of(inst);
                if (ill) m_ill = 1'b1;
            end
        end
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_ir_we", ir_we, 32'd0);
        chk("rst_illegal", illegal, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state, 32'd0);
        chk("reset_ir_we", ir_we, 32'd0);
        chk("reset_extop", EXTOp, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", illegal, 32'd0);
        rst = 1'b0;

        run(32'h00500093, 1'b1, 0, -1, ncyc);          // addi
        chk("addi_cycles", ncyc, 32'd4);
        chk("addi_instret", instret, 32'd1);
        chk("addi_extop", EXTOp, 32'h10);
        run(32'h00309093, 1'b0, 0, -1, ncyc);          // slli
        chk("slli_extop", EXTOp, 32'h20);

        cnt_re = 0;
        run(32'h0000A103, 1'b1, 2, -1, ncyc);          // lw, 2 wait cycles
        chk("lw_cycles", ncyc, 32'd7);
        chk("lw_mem_re_cycles", cnt_re, 32'd3);
        chk("lw_extop", EXTOp, 32'h10);

        cnt_we = 0;
        cnt_rf = 0;
        run(32'h0020A223, 1'b1, 0, -1, ncyc);          // sw
        chk("sw_cycles", ncyc, 32'd4);
        chk("sw_mem_we_cycles", cnt_we, 32'd1);
        chk("sw_rf_we_cycles", cnt_rf, 32'd0);
        chk("sw_extop", EXTOp, 32'h08);

        run(32'h00000463, 1'b1, 0, -1, ncyc);          // beq taken
        chk("beq_cycles", ncyc, 32'd3);
        chk("beq_extop", EXTOp, 32'h04);
        run(32'h00000463, 1'b0, 0, -1, ncyc);          // beq not taken
        run(32'h010000EF, 1'b1, 0, -1, ncyc);          // jal
        chk("jal_extop", EXTOp, 32'h01);
        run(32'h000080E7, 1'b0, 0, -1, ncyc);          // jalr
        run(32'h123450B7, 1'b1, 0, -1, ncyc);          // lui
        chk("lui_extop", EXTOp, 32'h02);
        run(32'h00001097, 1'b0, 0, -1, ncyc);          // auipc
        run(32'h002081B3, 1'b1, 0, -1, ncyc);          // add
        chk("add_extop", EXTOp, 32'h00);
        chk("seq_instret", instret, 32'd11);

        run(32'h00000000, 1'b1, 20, -1, ncyc);         // illegal -> halt
        chk("illegal_flag", illegal, 32'd1);
        chk("halt_state", state, 32'd5);
        chk("halt_instret", instret, 32'd11);

        do_reset();
        run(32'h00000073, 1'b1, 5, -1, ncyc);          // ecall -> halt
        chk("ecall_illegal", illegal, 32'd0);
        chk("ecall_state", state, 32'd5);

        do_reset();
        run(32'h00500093, 1'b0, 0, -1, ncyc);
        run(32'h0000A103, 1'b0, 3, 4, ncyc);           // lw aborted in second MEM cycle
        run(32'h00500093, 1'b0, 0, -1, ncyc);
        chk("post_abort_instret", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
